// File: rtl/phy_rx_serial_align.sv
// Per-lane serial receive aligner: finds the COM boundary, confirms lock, then emits data words.
// Optional build macro PHY_RX_WATCHDOG_EN drops lock after WDOG_WORDS words without a COM.
module phy_rx_serial_align #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] COM        = 8'hBC,
    parameter logic [WIDTH-1:0] IDLE       = 8'h7C,
    parameter int               LOCK_COUNT = 4,
    parameter int               WDOG_WORDS = 16
) (
    input  logic             clk32f,
    input  logic             reset,
    input  logic             in,
    output logic [WIDTH-1:0] out,
    output logic             valid_out,
    output logic             active,
    output logic             com_seen
);

    localparam int         BC_W   = $clog2(WIDTH);
    localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);

    if (WIDTH < 4 || WIDTH > 16) begin : g_bad_width
        $error("WIDTH must be in 4..16");
    end
    if (LOCK_COUNT < 1 || LOCK_COUNT > 15) begin : g_bad_lock
        $error("LOCK_COUNT must be in 1..15");
    end
    if (WDOG_WORDS < 1) begin : g_bad_wdog
        $error("WDOG_WORDS must be at least 1");
    end

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-2:0] hist;
    logic [BC_W-1:0]  bc;
    logic [3:0]       com_cnt;
    logic [WIDTH-1:0] word;
    logic             boundary;
    logic             is_com;
    logic             is_idle;

`ifdef PHY_RX_WATCHDOG_EN
    localparam int WD_W = $clog2(WDOG_WORDS + 1);
    logic [WD_W-1:0] wdog;
`endif

    // The word is the shift register contents after this clock's shift; only
    // the low WIDTH-1 bits need to be held since the newest bit is `in` itself.
    assign word     = {hist, in};
    assign boundary = (bc == BC_W'(WIDTH - 1));
    assign is_com   = (word == COM);
    assign is_idle  = (word == IDLE);

    always_ff @(posedge clk32f or negedge reset) begin
        if (!reset) begin
            state     <= SEARCH;
            hist      <= '0;
            bc        <= '0;
            com_cnt   <= '0;
            out       <= '0;
            valid_out <= 1'b0;
            active    <= 1'b0;
            com_seen  <= 1'b0;
`ifdef PHY_RX_WATCHDOG_EN
            wdog      <= '0;
`endif
        end else begin
            hist      <= word[WIDTH-2:0];
            valid_out <= 1'b0;
            com_seen  <= 1'b0;
            bc        <= boundary ? '0 : bc + 1'b1;

            case (state)
                SEARCH: begin
                    if (is_com) begin
                        bc       <= '0;
                        com_cnt  <= 4'd1;
                        com_seen <= 1'b1;
                        if (LOCK_COUNT == 1) begin
                            state  <= LOCKED;
                            active <= 1'b1;
`ifdef PHY_RX_WATCHDOG_EN
                            wdog   <= '0;
`endif
                        end else begin
                            state <= ALIGN;
                        end
                    end
                end

                ALIGN: begin
                    if (boundary) begin
                        if (is_com) begin
                            com_seen <= 1'b1;
                            if (com_cnt + 4'd1 >= LOCK_N) begin
                                com_cnt <= LOCK_N;
                                state   <= LOCKED;
                                active  <= 1'b1;
`ifdef PHY_RX_WATCHDOG_EN
                                wdog    <= '0;
`endif
                            end else begin
                                com_cnt <= com_cnt + 4'd1;
                            end
                        end else begin
                            com_cnt <= '0;
                            state   <= SEARCH;
                        end
                    end
                end

                LOCKED: begin
                    if (boundary) begin
                        if (is_com) begin
                            com_seen <= 1'b1;
`ifdef PHY_RX_WATCHDOG_EN
                            wdog     <= '0;
`endif
                        end else begin
                            if (!is_idle) begin
                                out       <= word;
                                valid_out <= 1'b1;
                            end
`ifdef PHY_RX_WATCHDOG_EN
                            // The timeout word itself is still delivered above.
                            if (wdog == WD_W'(WDOG_WORDS - 1)) begin
                                wdog    <= '0;
                                state   <= SEARCH;
                                active  <= 1'b0;
                                com_cnt <= '0;
                            end else begin
                                wdog <= wdog + 1'b1;
                            end
`endif
                        end
                    end
                end

                default: begin
                    state   <= SEARCH;
                    active  <= 1'b0;
                    com_cnt <= '0;
                end
            endcase
        end
    end

endmodule
